// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: receiver FSM state encoding, ns-to-cycle conversion and
// default timing constants (also used by the transmitter).
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } ws2812_state_e;

    localparam int unsigned DEF_CLK_HZ      = 27_000_000;
    localparam int unsigned DEF_T_THRESH_NS = 600;
    localparam int unsigned DEF_T_MIN_NS    = 150;
    localparam int unsigned DEF_T_MAX_NS    = 5000;
    localparam int unsigned DEF_T_RESET_NS  = 50000;

    // Rounds up so a timing limit is never undercut by truncation.
    function automatic int unsigned ns_to_cyc(input int unsigned ns, input int unsigned clk_hz);
        return 32'((64'(ns) * 64'(clk_hz) + 64'd999_999_999) / 64'd1_000_000_000);
    endfunction

endpackage

// File: rtl/ws2812_sync.sv
// Two-flop synchronizer for the WS2812 data line, plus one history flop for edge pulses.
module ws2812_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic ds,
    output logic rise,
    output logic fall
);
    // sr[1:0] is the synchronizer proper; sr[2] holds the previous ds for edge detection.
    logic [2:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr <= '0;
        else      sr <= {sr[1:0], din};
    end

    assign ds   = sr[1];
    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];
endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: decodes 24-bit GRB words, flags frame latches and malformed pulses.
// Define WS2812_RX_FORWARD_EN for daisy-chain mode (word 0 only, remainder forwarded on dout).
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
    parameter int unsigned T_THRESH_NS = DEF_T_THRESH_NS,
    parameter int unsigned T_MIN_NS    = DEF_T_MIN_NS,
    parameter int unsigned T_MAX_NS    = DEF_T_MAX_NS,
    parameter int unsigned T_RESET_NS  = DEF_T_RESET_NS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] color,
    output logic        valid,
    output logic [7:0]  pix_idx,
    output logic        latch,
    output logic        err,
    output logic        dout
);
    localparam int unsigned THRESH_CYC = ns_to_cyc(T_THRESH_NS, CLK_HZ);
    localparam int unsigned MIN_CYC    = ns_to_cyc(T_MIN_NS, CLK_HZ);
    localparam int unsigned MAX_CYC    = ns_to_cyc(T_MAX_NS, CLK_HZ);
    localparam int unsigned RESET_CYC  = ns_to_cyc(T_RESET_NS, CLK_HZ);
    localparam int HW = $clog2(MAX_CYC + 1);
    localparam int LW = $clog2(RESET_CYC + 1);

    localparam logic [HW-1:0] THRESH_C = HW'(THRESH_CYC);
    localparam logic [HW-1:0] MIN_C    = HW'(MIN_CYC);
    localparam logic [HW-1:0] MAX_C    = HW'(MAX_CYC);
    localparam logic [HW-1:0] MAX_M1   = HW'(MAX_CYC - 1);
    localparam logic [LW-1:0] RESET_M1 = LW'(RESET_CYC - 1);

    localparam logic [1:0] S_SYNC = ST_SYNC;
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_HIGH = ST_HIGH;
    localparam logic [1:0] S_LOW  = ST_LOW;

    logic          ds, rise, fall;
    logic [1:0]    state;
    logic [HW-1:0] high_cnt;
    logic [LW-1:0] low_cnt;
    logic [23:0]   shift;
    logic [4:0]    bit_cnt;
    logic [7:0]    word_cnt;
    logic          rise_pend;
    logic          decode_ok;

    ws2812_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .ds   (ds),
        .rise (rise),
        .fall (fall)
    );

`ifdef WS2812_RX_FORWARD_EN
    logic fwd;
    assign decode_ok = (word_cnt == 8'd0);
    // fwd is only set while ds is low, so forwarding always begins on a clean rising edge.
    assign dout = fwd & ds;
`else
    assign decode_ok = 1'b1;
    assign dout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_SYNC;
            high_cnt  <= '0;
            low_cnt   <= '0;
            shift     <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            rise_pend <= 1'b0;
            color     <= '0;
            pix_idx   <= '0;
            valid     <= 1'b0;
            latch     <= 1'b0;
            err       <= 1'b0;
`ifdef WS2812_RX_FORWARD_EN
            fwd       <= 1'b0;
`endif
        end else begin
            valid     <= 1'b0;
            latch     <= 1'b0;
            err       <= 1'b0;
            rise_pend <= 1'b0;

            // Publish one cycle after the 24th bit lands in the shift register.
            if (bit_cnt == 5'd24) begin
                bit_cnt <= '0;
                if (word_cnt != 8'hFF) word_cnt <= word_cnt + 8'd1;
                if (decode_ok) begin
                    color   <= shift;
                    valid   <= 1'b1;
                    pix_idx <= word_cnt;
                end
`ifdef WS2812_RX_FORWARD_EN
                fwd <= 1'b1;
`endif
            end

            case (state)
                S_SYNC: begin
                    if (ds) begin
                        low_cnt <= '0;
                    end else if (low_cnt == RESET_M1) begin
                        // A full gap marks a frame boundary; the next frame starts at word 0.
                        low_cnt  <= '0;
                        word_cnt <= '0;
                        bit_cnt  <= '0;
                        shift    <= '0;
                        state    <= S_IDLE;
                    end else begin
                        low_cnt <= low_cnt + LW'(1);
                    end
                end
                S_IDLE: begin
                    if (rise || rise_pend) begin
                        high_cnt <= HW'(1);
                        state    <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (fall && high_cnt >= MIN_C) begin
                        shift   <= {shift[22:0], (high_cnt >= THRESH_C)};
                        bit_cnt <= bit_cnt + 5'd1;
                        low_cnt <= '0;
                        state   <= S_LOW;
                    end else if (fall || high_cnt == MAX_M1) begin
                        high_cnt <= fall ? high_cnt : MAX_C;
                        err      <= 1'b1;
                        bit_cnt  <= '0;
                        shift    <= '0;
                        low_cnt  <= '0;
                        state    <= S_SYNC;
`ifdef WS2812_RX_FORWARD_EN
                        fwd      <= 1'b0;
`endif
                    end else begin
                        high_cnt <= high_cnt + HW'(1);
                    end
                end
                S_LOW: begin
                    if (low_cnt == RESET_M1) begin
                        // Latch takes priority; a coincident rising edge is replayed from IDLE.
                        latch     <= 1'b1;
                        err       <= (bit_cnt != 5'd0);
                        rise_pend <= rise;
                        word_cnt  <= '0;
                        bit_cnt   <= '0;
                        shift     <= '0;
                        low_cnt   <= '0;
                        state     <= S_IDLE;
`ifdef WS2812_RX_FORWARD_EN
                        fwd       <= 1'b0;
`endif
                    end else if (rise) begin
                        high_cnt <= HW'(1);
                        state    <= S_HIGH;
                    end else begin
                        low_cnt <= low_cnt + LW'(1);
                    end
                end
                default: state <= S_SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx at 27 MHz (T0H=11, T1H=22, 34-cycle bit period).
// Expectations follow the build: WS2812_RX_FORWARD_EN selects the daisy-chain checks.
`timescale 1ns/1ps
module tb_ws2812_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din = 1'b0;
    logic [23:0] color;
    logic        valid;
    logic [7:0]  pix_idx;
    logic        latch, err, dout;

    int errors = 0;
    int checks = 0;

    ws2812_rx dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .color   (color),
        .valid   (valid),
        .pix_idx (pix_idx),
        .latch   (latch),
        .err     (err),
        .dout    (dout)
    );

    always #18.5 clk = ~clk;

    // Event monitor: counts pulses and records decoded words; tasks compare deltas.
    int          cyc = 0;
    int          n_valid = 0, n_latch = 0, n_err = 0, n_latch_err = 0, n_both = 0;
    int          n_dout_rise = 0, n_fwd_mis = 0;
    int          last_valid_cyc = 0, last_latch_cyc = 0, last_err_cyc = 0;
    logic [23:0] vcol [64];
    logic [7:0]  vidx [64];
    logic        dout_q = 1'b0;
    logic        din_d1 = 1'b0, din_d2 = 1'b0;
    bit          fwd_watch = 1'b0;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        din_d1 <= din;
        din_d2 <= din_d1;
    end

    always @(negedge clk) begin
        dout_q <= dout;
        if (dout && !dout_q) n_dout_rise++;
        if (fwd_watch && dout !== din_d2) n_fwd_mis++;
        if (valid) begin
            vcol[n_valid % 64] = color;
            vidx[n_valid % 64] = pix_idx;
            n_valid++;
            last_valid_cyc = cyc;
            $display("cyc %0d: valid color=%06h pix_idx=%0d", cyc, color, pix_idx);
        end
        if (latch) begin
            n_latch++;
            last_latch_cyc = cyc;
            $display("cyc %0d: latch", cyc);
        end
        if (err) begin
            n_err++;
            last_err_cyc = cyc;
            $display("cyc %0d: err", cyc);
        end
        if (latch && err) n_latch_err++;
        if (latch && valid) n_both++;
    end

    task automatic low(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        int h;
        h = b ? 22 : 11;
        din = 1'b1;
        repeat (h) @(negedge clk);
        din = 1'b0;
        repeat (34 - h) @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[23 - i]);
    endtask

    task automatic send_word(input logic [23:0] w);
        send_bits(w, 24);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        din = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (color !== 24'h0)  begin errors++; $display("FAIL reset_color: got %h want %h", color, 24'h0); end
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (pix_idx !== 8'd0) begin errors++; $display("FAIL reset_pix_idx: got %0d want 0", pix_idx); end
        checks++; if (latch !== 1'b0)   begin errors++; $display("FAIL reset_latch: got %b want 0", latch); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (dout !== 1'b0)    begin errors++; $display("FAIL reset_dout: got %b want 0", dout); end
        rst = 1'b1;
    endtask

    task automatic test_first_word();
        int bv, bl, be;
        bv = n_valid; bl = n_latch; be = n_err;
        low(1400);
        checks++; if (n_latch - bl !== 0) begin errors++; $display("FAIL powerup_no_latch: got %0d want 0", n_latch - bl); end
        send_word(24'hFF0000);
        low(20);
        checks++; if (n_valid - bv !== 1) begin errors++; $display("FAIL first_valid_count: got %0d want 1", n_valid - bv); end
        checks++; if (color !== 24'hFF0000) begin errors++; $display("FAIL first_color: got %h want %h", color, 24'hFF0000); end
        checks++; if (pix_idx !== 8'd0) begin errors++; $display("FAIL first_pix_idx: got %0d want 0", pix_idx); end
        low(1400);
        checks++; if (n_latch - bl !== 1) begin errors++; $display("FAIL first_latch: got %0d want 1", n_latch - bl); end
        checks++; if (n_err - be !== 0) begin errors++; $display("FAIL first_err: got %0d want 0", n_err - be); end
    endtask

    task automatic test_three_words();
        int bv, bl, be, bd, bm, bb;
        bv = n_valid; bl = n_latch; be = n_err; bd = n_dout_rise; bm = n_fwd_mis; bb = n_both;
        send_word(24'h00FF00);
        fwd_watch = 1'b1;
        send_word(24'h0000FF);
        send_word(24'h123456);
        low(10);
        fwd_watch = 1'b0;
        low(1390);
`ifdef WS2812_RX_FORWARD_EN
        checks++; if (n_valid - bv !== 1) begin errors++; $display("FAIL fwd_valid_count: got %0d want 1", n_valid - bv); end
        checks++; if (color !== 24'h00FF00) begin errors++; $display("FAIL fwd_color: got %h want %h", color, 24'h00FF00); end
        checks++; if (pix_idx !== 8'd0) begin errors++; $display("FAIL fwd_pix_idx: got %0d want 0", pix_idx); end
        checks++; if (n_fwd_mis - bm !== 0) begin errors++; $display("FAIL fwd_dout_replica: got %0d mismatching cycles want 0", n_fwd_mis - bm); end
        checks++; if (n_dout_rise - bd !== 48) begin errors++; $display("FAIL fwd_dout_pulses: got %0d want 48", n_dout_rise - bd); end
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL fwd_dout_after_latch: got %b want 0", dout); end
`else
        checks++; if (n_valid - bv !== 3) begin errors++; $display("FAIL multi_valid_count: got %0d want 3", n_valid - bv); end
        checks++; if (vcol[bv % 64] !== 24'h00FF00) begin errors++; $display("FAIL multi_color0: got %h want %h", vcol[bv % 64], 24'h00FF00); end
        checks++; if (vcol[(bv + 1) % 64] !== 24'h0000FF) begin errors++; $display("FAIL multi_color1: got %h want %h", vcol[(bv + 1) % 64], 24'h0000FF); end
        checks++; if (vcol[(bv + 2) % 64] !== 24'h123456) begin errors++; $display("FAIL multi_color2: got %h want %h", vcol[(bv + 2) % 64], 24'h123456); end
        checks++; if (vidx[bv % 64] !== 8'd0) begin errors++; $display("FAIL multi_idx0: got %0d want 0", vidx[bv % 64]); end
        checks++; if (vidx[(bv + 1) % 64] !== 8'd1) begin errors++; $display("FAIL multi_idx1: got %0d want 1", vidx[(bv + 1) % 64]); end
        checks++; if (vidx[(bv + 2) % 64] !== 8'd2) begin errors++; $display("FAIL multi_idx2: got %0d want 2", vidx[(bv + 2) % 64]); end
        checks++; if (n_dout_rise - bd !== 0) begin errors++; $display("FAIL multi_dout_idle: got %0d pulses want 0", n_dout_rise - bd); end
`endif
        checks++; if (n_latch - bl !== 1) begin errors++; $display("FAIL multi_latch: got %0d want 1", n_latch - bl); end
        checks++; if (n_err - be !== 0) begin errors++; $display("FAIL multi_err: got %0d want 0", n_err - be); end
        checks++; if (n_both - bb !== 0) begin errors++; $display("FAIL multi_valid_latch_overlap: got %0d want 0", n_both - bb); end
        checks++; if (!(last_valid_cyc < last_latch_cyc)) begin errors++; $display("FAIL multi_valid_before_latch: valid@%0d latch@%0d", last_valid_cyc, last_latch_cyc); end
    endtask

    task automatic test_truncated();
        int bv, bl, be, ble;
        logic [23:0] exp_col;
`ifdef WS2812_RX_FORWARD_EN
        exp_col = 24'h00FF00;
`else
        exp_col = 24'h123456;
`endif
        bv = n_valid; bl = n_latch; be = n_err; ble = n_latch_err;
        send_bits(24'hABC000, 12);
        low(1400);
        checks++; if (n_latch - bl !== 1) begin errors++; $display("FAIL trunc_latch: got %0d want 1", n_latch - bl); end
        checks++; if (n_err - be !== 1) begin errors++; $display("FAIL trunc_err: got %0d want 1", n_err - be); end
        checks++; if (n_latch_err - ble !== 1) begin errors++; $display("FAIL trunc_same_cycle: got %0d want 1", n_latch_err - ble); end
        checks++; if (n_valid - bv !== 0) begin errors++; $display("FAIL trunc_valid: got %0d want 0", n_valid - bv); end
        checks++; if (color !== exp_col) begin errors++; $display("FAIL trunc_color_held: got %h want %h", color, exp_col); end
    endtask

    task automatic test_glitch();
        int bv, bl, be, c0;
        bv = n_valid; bl = n_latch; be = n_err;
        din = 1'b1;
        repeat (3) @(negedge clk);
        low(40);
        checks++; if (n_err - be !== 1) begin errors++; $display("FAIL glitch_short_err: got %0d want 1", n_err - be); end
        send_word(24'hA5A5A5);
        low(20);
        checks++; if (n_valid - bv !== 0) begin errors++; $display("FAIL glitch_word_ignored: got %0d valid want 0", n_valid - bv); end
        checks++; if (n_err - be !== 1) begin errors++; $display("FAIL glitch_sync_quiet: got %0d err want 1", n_err - be); end
        low(1400);
        checks++; if (n_latch - bl !== 0) begin errors++; $display("FAIL glitch_sync_no_latch: got %0d want 0", n_latch - bl); end
        send_word(24'h0F0F0F);
        low(20);
        checks++; if (n_valid - bv !== 1) begin errors++; $display("FAIL glitch_resync_valid: got %0d want 1", n_valid - bv); end
        checks++; if (color !== 24'h0F0F0F) begin errors++; $display("FAIL glitch_resync_color: got %h want %h", color, 24'h0F0F0F); end
        checks++; if (pix_idx !== 8'd0) begin errors++; $display("FAIL glitch_resync_idx: got %0d want 0", pix_idx); end
        low(1400);
        bv = n_valid; bl = n_latch; be = n_err;
        c0 = cyc;
        din = 1'b1;
        repeat (200) @(negedge clk);
        low(1400);
        checks++; if (n_err - be !== 1) begin errors++; $display("FAIL long_pulse_err: got %0d want 1", n_err - be); end
        checks++; if (last_err_cyc - c0 !== 137) begin errors++; $display("FAIL long_pulse_err_time: got %0d want 137", last_err_cyc - c0); end
        checks++; if (n_latch - bl !== 0) begin errors++; $display("FAIL long_pulse_no_latch: got %0d want 0", n_latch - bl); end
        checks++; if (n_valid - bv !== 0) begin errors++; $display("FAIL long_pulse_valid: got %0d want 0", n_valid - bv); end
    endtask

    task automatic test_async_reset();
        int bv, be;
        send_word(24'h0F0F0F);
        low(10);
        send_bits(24'hFFFFFF, 9);
        din = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (color !== 24'h0)  begin errors++; $display("FAIL arst_color: got %h want %h", color, 24'h0); end
        checks++; if (pix_idx !== 8'd0) begin errors++; $display("FAIL arst_pix_idx: got %0d want 0", pix_idx); end
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL arst_valid: got %b want 0", valid); end
        checks++; if (latch !== 1'b0)   begin errors++; $display("FAIL arst_latch: got %b want 0", latch); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL arst_err: got %b want 0", err); end
        checks++; if (dout !== 1'b0)    begin errors++; $display("FAIL arst_dout: got %b want 0", dout); end
        @(negedge clk);
        din = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bv = n_valid; be = n_err;
        send_word(24'h111111);
        low(20);
        checks++; if (n_valid - bv !== 0) begin errors++; $display("FAIL arst_word_ignored: got %0d want 0", n_valid - bv); end
        low(1400);
        send_word(24'h222222);
        low(20);
        checks++; if (n_valid - bv !== 1) begin errors++; $display("FAIL arst_recover_valid: got %0d want 1", n_valid - bv); end
        checks++; if (color !== 24'h222222) begin errors++; $display("FAIL arst_recover_color: got %h want %h", color, 24'h222222); end
        checks++; if (pix_idx !== 8'd0) begin errors++; $display("FAIL arst_recover_idx: got %0d want 0", pix_idx); end
        checks++; if (n_err - be !== 0) begin errors++; $display("FAIL arst_recover_err: got %0d want 0", n_err - be); end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_three_words();
        test_truncated();
        test_glitch();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ws2812_rx.md
WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 Parameter CLK_HZ, default 27_000_000, system clock frequency in Hz.
REQ-002 Parameter T_THRESH_NS, default 600, high-pulse width at or above which a bit decodes as 1.
REQ-003 Parameter T_MIN_NS, default 150, shortest legal high pulse.
REQ-004 Parameter T_MAX_NS, default 5000, longest legal high pulse.
REQ-005 Parameter T_RESET_NS, default 50000, low time that marks a frame latch.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 rst  input  1  one clock; reset is asynchronous and active-low.
REQ-008 din  input  1  asynchronous WS2812 data line.
REQ-009 color  output  24  last decoded word, GRB order, G[7] in bit 23.
REQ-010 valid  output  1  one-cycle pulse when color updates.
REQ-011 pix_idx  output  8  index of the word in color within the current frame, 0-based.
REQ-012 latch  output  1  one-cycle pulse on detected reset/latch gap.
REQ-013 err  output  1  one-cycle pulse on a malformed pulse or truncated word.
REQ-014 dout  output  1  forwarded data line (see Configuration).

Function
REQ-015 Cycle constants: X_CYC = ceil(X_NS*CLK_HZ/1e9). At defaults THRESH=17, MIN=5, MAX=135, RESET=1350.
REQ-016 din passes a 2-FF synchronizer; all decoding uses the synchronized signal ds. Edge detection compares ds with its previous value.
REQ-017 FSM states: SYNC, IDLE, HIGH, LOW.
REQ-018 SYNC: low counter runs while ds=0 and clears on ds=1. On reaching RESET_CYC, go to IDLE. No latch pulse is issued from SYNC.
REQ-019 IDLE/LOW: a rising edge of ds enters HIGH with the high counter cleared to 1.
REQ-020 HIGH: the high counter saturates at MAX_CYC.
  - Counter reaches MAX_CYC: err pulse, discard the partial word, go to SYNC.
  - Falling edge with count < MIN_CYC: err pulse, discard, go to SYNC.
  - Otherwise: shift bit (count >= THRESH_CYC) into the shift register LSB, increment bit_cnt, go to LOW with the low counter cleared.
REQ-021 When the 24th bit shifts in, color updates and valid pulses on the next clk edge (2 cycles after the ds falling edge).
  - pix_idx takes the current word counter, which then increments (saturating at 255).
  - bit_cnt returns to 0.
REQ-022 LOW: the low counter reaching RESET_CYC produces a latch pulse and a return to IDLE.
  - Word counter and bit_cnt clear.
  - If bit_cnt was nonzero, err also pulses in the same cycle and the partial word is dropped.
REQ-023 A rising edge in the same cycle the low counter hits RESET_CYC: latch wins, and the edge starts a new HIGH in the following cycle.
REQ-024 valid and latch never assert in the same cycle; valid for a word always precedes that frame's latch.
REQ-025 color holds its value between valid pulses; latch does not modify color or pix_idx.

Reset
REQ-026 While rst=0: the FSM is in SYNC, all counters and the shift register are 0, color=0, pix_idx=0, and valid, latch, err and dout are 0. Both synchronizer flops are 0.
REQ-027 Deassertion mid-frame restarts in SYNC: the receiver ignores the rest of the frame until a full reset gap is seen.

Configuration
REQ-028 Macro WS2812_RX_FORWARD_EN defined: daisy-chain pixel behaviour.
  - Only word 0 of each frame is decoded (valid at most once per frame).
  - After word 0 completes, dout = ds until the next latch or SYNC entry; otherwise dout=0.
  - Forwarding starts with the first rising edge after word 0, so no truncated pulse is emitted.
REQ-029 Macro undefined: every complete word in the frame is decoded with an incrementing pix_idx, and dout is tied to 0.

Structure
REQ-030 Package ws2812_pkg holds the FSM state enum, the ns-to-cycle conversion function and the default timing constants. The existing transmitter also uses this package.
REQ-031 One sub-module, ws2812_sync: a 2-FF synchronizer with rise/fall pulse outputs.

Verification (27 MHz; drive din with T0H=11, T1H=22, bit period 34 cycles)
REQ-032 Power-up: din low 1400 cycles, then word 0xFF0000 -> valid once, color=0xFF0000, pix_idx=0, err=0.
REQ-033 Three words 0x00FF00, 0x0000FF, 0x123456, then 1400 low (macro undefined) -> valid x3, pix_idx 0,1,2, then one latch pulse and no err.
REQ-034 Same stimulus with WS2812_RX_FORWARD_EN -> a single valid with 0x00FF00; dout replicates the last 48 bits exactly (2-cycle lag); dout=0 after latch.
REQ-035 12 bits then 1400 low -> latch and err pulse in the same cycle, no valid; color is unchanged.
REQ-036 Glitches: a 3-cycle high pulse -> err, FSM in SYNC, and the following word is ignored until a 1350-cycle low gap. A 200-cycle high -> err at cycle 135 of the pulse.
REQ-037 rst asserted at bit 10 of a word -> all outputs 0 immediately (asynchronous); after release a full frame is needed before the next valid.
